line_buffer_conv1: RTL and testbench
====================================

# line_buffer_conv1

Sliding-window line buffer for the first convolution layer. It sits directly downstream of the conv1 controller. It consumes the controller's `rd_en`, `is_padding`, `buffer_en` and `pe_en` together with the input-FIFO read data, and holds the most recent K-1 padded rows plus K pixels. It presents a packed KxK window with a valid strobe to the PE array, and flags the end of each padded frame.

## Interface
- `pDATA_WIDTH`, 8: bits per channel sample.
- `pIN_CHANNEL`, 3: channels packed per pixel word.
- `pINPUT_WIDTH`, 4: unpadded image width.
- `pINPUT_HEIGHT`, 4: unpadded image height.
- `pKERNEL_SIZE`, 3: window size K.
- `pPADDING`, 1: zero-padding P on every border.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_data` in pDATA_WIDTH*pIN_CHANNEL: FIFO read data, valid the cycle after `rd_en`.
- `is_padding` in 1: controller padding flag (combinational, same cycle as `rd_en`).
- `buffer_en` in 1: controller shift strobe, already one cycle after `rd_en`/`is_padding`.
- `pe_en` in 1: controller window-compute strobe.
- `o_window` out K*K*pDATA_WIDTH*pIN_CHANNEL: packed window. Element (r,c) occupies slot r*K+c, with slot 0 at the LSBs. Row 0 is the oldest (top) row and column 0 is the leftmost column.
- `o_valid` out 1: `o_window` is a legal window for the PE.
- `o_frame_done` out 1: one-cycle pulse after the last padded pixel of a frame is shifted in.

## Operation
- Padded row length `L = pINPUT_WIDTH + 2*pPADDING`. Shift-register depth `D = (K-1)*L + K` pixel words. Index 0 holds the newest pixel.
- `pad_d1` is `is_padding` registered with no enable. It aligns with `buffer_en`.
- Shift: when `buffer_en` is high, `sreg[0]` loads 0 if `pad_d1`, otherwise `i_data`. For all i ≥ 1, `sreg[i]` loads `sreg[i-1]`. When `buffer_en` is low, all entries hold.
- Window tap: element (r,c) = `sreg[(K-1-r)*L + (K-1-c)]`. The taps are pure wiring from the registers, with no extra flop.
- Position tracking: internal `col_cntr_r` (0..L-1) and `row_cntr_r` (0..pINPUT_HEIGHT+2P-1) advance on each `buffer_en`.
  - `col_cntr_r` wraps to 0 at L-1 and then increments `row_cntr_r`.
  - `row_cntr_r` wraps to 0 after the last padded row.
- Fill counter `fill_cntr_r` saturates at D. It increments on `buffer_en` and clears to 0 when the frame wraps.
  - The shift registers are not cleared at frame wrap. Stale data is masked by the fill check.
- `pe_en` pipeline: `pe_en_d1` then `pe_en_d2` (two flops, no enable).
- `o_valid = pe_en_d2 && (fill_cntr_r == D)`. The PE never sees a partially filled window.
- `o_frame_done` is registered. It is set in the cycle after a `buffer_en` that occurs with `col_cntr_r == L-1` and `row_cntr_r == last row`.
- Simultaneous `buffer_en` and frame wrap: the shifted-in pixel counts toward the old frame. Fill and position then restart at 0 for the next pixel.
- Reset mid-frame:
  - All `sreg` entries, counters, `pad_d1`, `pe_en_d1`, `pe_en_d2` and `o_frame_done` go to 0 on the next edge.
  - Any window in flight is dropped, and `o_valid` is 0 until refilled.
- Width rules:
  - Counters are `$clog2` of their range, with minimum width 1.
  - `fill_cntr_r` is `$clog2(D+1)` bits.

## Timing
- Reset values: `o_window` = 0, `o_valid` = 0, `o_frame_done` = 0.
- Controller cycle t asserts `rd_en`/`is_padding` for pixel p:
  - t+1: `buffer_en` is high and p is written at the edge ending t+1.
  - t+2: p is visible at `sreg[0]`.
- A `pe_en` at cycle t yields `o_valid` at t+2, with `o_window` containing every pixel shifted through t+1.
- No back-pressure. Stalls propagate solely via `buffer_en`/`pe_en` being low, and window contents hold during stalls.
- `o_frame_done` is high for exactly one cycle per frame, in the cycle after the last shift.

## Test plan
1. Reset value check: hold `rst` for 3 cycles mid-stream, then release. Required: `o_valid`=0, `o_frame_done`=0 and `o_window`=0 immediately after reset, and no `o_valid` before 15 new shifts (D=2*6+3).
2. Defaults, pixels 1..16 row-major with the controller's padding pattern, `pe_en` at the first stride-2 window. Required: `o_window` slots 0..8 = {0,0,0,0,1,2,0,5,6} at `o_valid`.
3. Full frame at stride 2. Required:
   - exactly 4 `o_valid` pulses;
   - last window = {6,7,8,10,11,12,14,15,16};
   - `o_frame_done` pulses once, one cycle after the 36th shift.
4. Stall: drop `buffer_en` and `pe_en` for 5 cycles mid-row. Required: `o_window` is unchanged throughout and `o_valid` stays low.
5. Back-to-back frames, with the second frame using pixels 101..116. Required: the second frame's first valid window is {0,0,0,0,101,102,0,105,106}, with no pixels leaking from the first frame.
6. `pe_en` asserted while `fill_cntr_r` < D (forced early). Required: `o_valid` stays 0.

Source files
------------

// File: rtl/line_buffer_conv1.sv
// Sliding-window line buffer for conv1: keeps K-1 padded rows plus K pixels
// and presents a packed KxK window to the PE array.
module line_buffer_conv1 #(
  parameter int pDATA_WIDTH   = 8,
  parameter int pIN_CHANNEL   = 3,
  parameter int pINPUT_WIDTH  = 4,
  parameter int pINPUT_HEIGHT = 4,
  parameter int pKERNEL_SIZE  = 3,
  parameter int pPADDING      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0] i_data,
  input  logic is_padding,
  input  logic buffer_en,
  input  logic pe_en,
  output logic [pKERNEL_SIZE*pKERNEL_SIZE*pDATA_WIDTH*pIN_CHANNEL-1:0] o_window,
  output logic o_valid,
  output logic o_frame_done
);

  localparam int K  = pKERNEL_SIZE;
  localparam int PW = pDATA_WIDTH * pIN_CHANNEL;
  localparam int L  = pINPUT_WIDTH + 2 * pPADDING;
  localparam int H  = pINPUT_HEIGHT + 2 * pPADDING;
  localparam int D  = (K - 1) * L + K;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int FW = $clog2(D + 1);

  logic [PW-1:0] sreg [D];
  logic [CW-1:0] col_cntr_r;
  logic [RW-1:0] row_cntr_r;
  logic [FW-1:0] fill_cntr_r;
  logic pad_d1;
  logic pe_en_d1;
  logic pe_en_d2;
  logic col_last;
  logic row_last;
  logic frame_wrap;

  assign col_last   = (col_cntr_r == CW'(L - 1));
  assign row_last   = (row_cntr_r == RW'(H - 1));
  assign frame_wrap = buffer_en && col_last && row_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) sreg[i] <= '0;
    end else if (buffer_en) begin
      sreg[0] <= pad_d1 ? '0 : i_data;
      for (int i = 1; i < D; i++) sreg[i] <= sreg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cntr_r   <= '0;
      row_cntr_r   <= '0;
      fill_cntr_r  <= '0;
      pad_d1       <= 1'b0;
      pe_en_d1     <= 1'b0;
      pe_en_d2     <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      pad_d1       <= is_padding;
      pe_en_d1     <= pe_en;
      pe_en_d2     <= pe_en_d1;
      o_frame_done <= frame_wrap;
      if (buffer_en) begin
        if (col_last) begin
          col_cntr_r <= '0;
          row_cntr_r <= row_last ? '0 : row_cntr_r + RW'(1);
        end else begin
          col_cntr_r <= col_cntr_r + CW'(1);
        end
      end
      // Stale rows from the previous frame stay in sreg; the fill count masks them.
      if (frame_wrap) begin
        fill_cntr_r <= '0;
      end else if (buffer_en && (fill_cntr_r != FW'(D))) begin
        fill_cntr_r <= fill_cntr_r + FW'(1);
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign o_window[(r*K+c)*PW +: PW] = sreg[(K-1-r)*L + (K-1-c)];
    end
  end

  assign o_valid = pe_en_d2 && (fill_cntr_r == FW'(D));

endmodule

// File: tb/tb_line_buffer_conv1.sv
// Bench for line_buffer_conv1: frame-level model of the padded image
// compared every cycle, plus hand-computed window literals.
module tb_line_buffer_conv1;

  localparam int K   = 3;
  localparam int PW  = 24;
  localparam int L   = 6;
  localparam int H   = 6;
  localparam int D   = 15;
  localparam int WW  = K * K * PW;
  localparam int NPX = L * H;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] i_data;
  logic is_padding;
  logic buffer_en;
  logic pe_en;
  logic [WW-1:0] o_window;
  logic o_valid;
  logic o_frame_done;

  always #5 clk = ~clk;

  line_buffer_conv1 dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .is_padding   (is_padding),
    .buffer_en    (buffer_en),
    .pe_en        (pe_en),
    .o_window     (o_window),
    .o_valid      (o_valid),
    .o_frame_done (o_frame_done)
  );

  // Model: pixels of the current padded frame in arrival order.
  logic [PW-1:0] mframe [NPX];
  int mn;
  bit md1, md2, mdone;
  bit nxt_en, pad_prev;
  logic [PW-1:0] nxt_data;

  int total, bad;
  bit chk_en;
  int vcount, dcount;
  logic [WW-1:0] win_log [64];

  string lit_name;
  logic [WW-1:0] lit_act, lit_exp;
  int lit_seq, lit_seen;

  logic [WW-1:0] stall_a, stall_b;
  int stall_v;

  function automatic logic [PW-1:0] px(input int v);
    logic [7:0] b;
    b = 8'(v);
    return (v == 0) ? '0 : {b, b ^ 8'h5A, b ^ 8'hC3};
  endfunction

  function automatic logic [WW-1:0] pk9(input int a0, a1, a2, a3, a4,
                                        input int a5, a6, a7, a8);
    int a [9];
    logic [WW-1:0] w;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int s = 0; s < 9; s++) w[s*PW +: PW] = px(a[s]);
    return w;
  endfunction

  // Window whose bottom-right corner is the newest pixel of the frame.
  function automatic logic [WW-1:0] exp_win();
    logic [WW-1:0] w;
    int back;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        back = (K - 1 - r) * L + (K - 1 - c);
        w[(r*K+c)*PW +: PW] = mframe[mn - 1 - back];
      end
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (lit_seq != lit_seen) begin
        total++;
        if (lit_act !== lit_exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", lit_name, lit_act, lit_exp);
        end
        lit_seen = lit_seq;
      end
      total++;
      if (o_valid !== (md2 && mn >= D)) begin
        bad++;
        $display("FAIL valid t=%0t: got %b want %b", $time, o_valid,
                 md2 && mn >= D);
      end
      total++;
      if (o_frame_done !== mdone) begin
        bad++;
        $display("FAIL frame_done t=%0t: got %b want %b", $time,
                 o_frame_done, mdone);
      end
      if (mn >= D) begin
        total++;
        if (o_window !== exp_win()) begin
          bad++;
          $display("FAIL window t=%0t: got %h want %h", $time, o_window,
                   exp_win());
        end
      end
      if (o_valid === 1'b1 && vcount < 64) begin
        win_log[vcount] = o_window;
        vcount++;
      end
      if (o_frame_done === 1'b1) dcount++;
    end
  end

  task automatic lit(input string name, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    lit_name = name;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  // One controller cycle: rd/pad for a new pixel, shift for the previous one.
  task automatic step(input bit rd, input bit pad, input logic [PW-1:0] d,
                      input bit pe);
    logic [PW-1:0] shifted;
    bit en;
    en = nxt_en;
    shifted = pad_prev ? '0 : nxt_data;
    buffer_en  = en;
    i_data     = nxt_data;
    is_padding = rd & pad;
    pe_en      = pe;
    @(posedge clk);
    #1;
    md2 = md1;
    md1 = pe;
    mdone = 1'b0;
    if (en) begin
      mframe[mn] = shifted;
      mn++;
      if (mn == NPX) begin
        mn = 0;
        mdone = 1'b1;
      end
    end
    nxt_en = rd;
    nxt_data = d;
    pad_prev = rd & pad;
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    chk_en = 1'b0;
    rst = 1'b1;
    buffer_en = 1'b0;
    pe_en = 1'b0;
    is_padding = 1'b0;
    i_data = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    mn = 0;
    md1 = 1'b0;
    md2 = 1'b0;
    mdone = 1'b0;
    nxt_en = 1'b0;
    pad_prev = 1'b0;
    nxt_data = '0;
    chk_en = 1'b1;
  endtask

  // mode 0: stride-2 pe_en; mode 1: pe_en on the first 14 pixels only.
  task automatic run_frame(input int base, input int mode, input int stall_at,
                           input int npx);
    int i, v0;
    bit pad, pe;
    logic [PW-1:0] d;
    for (int pr = 0; pr < H; pr++)
      for (int pc = 0; pc < L; pc++) begin
        i = pr * L + pc;
        if (i < npx) begin
          pad = (pr == 0) || (pr == H - 1) || (pc == 0) || (pc == L - 1);
          d = pad ? 24'hEEEEEE : px(base + (pr - 1) * 4 + (pc - 1));
          if (mode == 0)
            pe = pr >= 2 && pc >= 2 && pr % 2 == 0 && pc % 2 == 0;
          else
            pe = (i < 14);
          if (i == stall_at) begin
            step(1'b0, 1'b0, '0, 1'b0);
            stall_a = o_window;
            v0 = vcount;
            repeat (4) step(1'b0, 1'b0, '0, 1'b0);
            stall_b = o_window;
            stall_v = vcount - v0;
          end
          step(1'b1, pad, d, pe);
        end
      end
  endtask

  initial begin
    int v0, d0;
    total = 0;
    bad = 0;
    vcount = 0;
    dcount = 0;
    lit_seq = 0;
    lit_seen = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    do_reset(3);
    lit("rst_window", o_window, '0);
    lit("rst_valid", WW'(o_valid), '0);
    lit("rst_done", WW'(o_frame_done), '0);

    v0 = vcount;
    d0 = dcount;
    run_frame(1, 0, -1, NPX);
    flush(4);
    lit("f1_nvalid", WW'(vcount - v0), WW'(4));
    lit("f1_first", win_log[v0], pk9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    lit("f1_last", win_log[v0+3], pk9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    lit("f1_done", WW'(dcount - d0), WW'(1));

    run_frame(1, 0, -1, NPX);
    v0 = vcount;
    run_frame(101, 0, 21, NPX);
    flush(4);
    lit("f2_nvalid", WW'(vcount - v0), WW'(4));
    lit("f2_first", win_log[v0],
        pk9(0, 0, 0, 0, 101, 102, 0, 105, 106));
    lit("f2_last", win_log[v0+3],
        pk9(106, 107, 108, 110, 111, 112, 114, 115, 116));
    lit("stall_start", stall_a, pk9(0, 101, 102, 0, 105, 106, 0, 109, 110));
    lit("stall_end", stall_b, pk9(0, 101, 102, 0, 105, 106, 0, 109, 110));
    lit("stall_valid", WW'(stall_v), '0);

    run_frame(1, 0, -1, 20);
    do_reset(3);
    lit("mid_rst_window", o_window, '0);
    lit("mid_rst_valid", WW'(o_valid), '0);
    lit("mid_rst_done", WW'(o_frame_done), '0);

    v0 = vcount;
    run_frame(1, 1, -1, NPX);
    flush(4);
    lit("early_nvalid", WW'(vcount - v0), '0);

    v0 = vcount;
    d0 = dcount;
    run_frame(1, 0, -1, NPX);
    flush(4);
    lit("f4_nvalid", WW'(vcount - v0), WW'(4));
    lit("f4_last", win_log[v0+3], pk9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    lit("f4_done", WW'(dcount - d0), WW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
